// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// pll_lock_supervisor
// Sequences the PLL reset/lock handshake on the reference clock and releases
// a synchronous system reset once lock has been held for a qualified time.
// Lock loss or lock timeout re-pulses the PLL reset. After a bounded number of
// timed-out attempts the block parks in a sticky failure state.
//
// Ports
//   clk          in   reference clock (also the PLL input clock)
//   reset_n      in   asynchronous active-low reset
//   pll_lock     in   PLL lock, asynchronous, synchronized internally
//   pll_reset    out  PLL reset, active-high
//   sys_reset_n  out  synchronous active-low reset for downstream logic
//   locked       out  high only while running
//   fail         out  sticky failure flag
//   retry_count  out  timed-out attempts in the current bring-up
//   loss_count   out  loss-of-lock events seen while running, saturating
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_RESET_PLL | PLL reset asserted for RST_PULSE_CYCLES
// S_WAIT_LOCK | PLL reset released, waiting for lock or timeout
// S_STABLE    | lock seen, qualifying for LOCK_STABLE_CYCLES unbroken cycles
// S_RUN       | system reset released, watching for loss of lock
// S_FAIL      | retries exhausted, terminal until reset_n
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 27,
    parameter int LOCK_TIMEOUT_CYCLES = 2700000,
    parameter int LOCK_STABLE_CYCLES  = 2700,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset_n,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [7:0] loss_count
);

    localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                               RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ?
                               CNT_MAX_A : LOCK_STABLE_CYCLES;
    localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          sync1_q, lock_s_q;
    logic          pll_reset_q, sys_reset_n_q, locked_q, fail_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        unique case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same edge.
                if (lock_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q + 4'd1 == RETRY_MAX) begin
                        state_d = S_FAIL;
                        retry_d = RETRY_MAX;
                    end else begin
                        state_d = S_RESET_PLL;
                        retry_d = retry_q + 4'd1;
                    end
                end
            end
            S_STABLE: begin
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STB_LAST) begin
                    state_d = S_RUN;
                    retry_d = 4'd0;
                end
            end
            S_RUN: begin
                if (!lock_s_q) begin
                    state_d = S_RESET_PLL;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase
    end

    // One shared timer: restarts on every state change, idles in RUN/FAIL.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_RESET_PLL || state_q == S_WAIT_LOCK ||
                     state_q == S_STABLE) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_RESET_PLL;
            cnt_q         <= '0;
            retry_q       <= 4'd0;
            loss_q        <= 8'd0;
            pll_reset_q   <= 1'b1;
            sys_reset_n_q <= 1'b0;
            locked_q      <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            loss_q        <= loss_d;
            // Outputs decoded from the next state so they move with the state.
            pll_reset_q   <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
            sys_reset_n_q <= (state_d == S_RUN);
            locked_q      <= (state_d == S_RUN);
            fail_q        <= (state_d == S_FAIL);
        end
    end

    assign pll_reset   = pll_reset_q;
    assign sys_reset_n = sys_reset_n_q;
    assign locked      = locked_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;
    assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps
// Testbench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

    localparam int P_RST = 4;
    localparam int P_TO  = 20;
    localparam int P_ST  = 8;
    localparam int P_MR  = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset, sys_reset_n, locked, fail;
    logic [3:0] retry_count;
    logic [7:0] loss_count;

    int n_vec = 0;
    int n_err = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (P_RST),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .LOCK_STABLE_CYCLES (P_ST),
        .MAX_RETRIES        (P_MR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .sys_reset_n(sys_reset_n),
        .locked     (locked),
        .fail       (fail),
        .retry_count(retry_count),
        .loss_count (loss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus elapsed edges in that phase, lock seen
    // through a two-edge delay line.
    typedef enum {M_PULSE, M_WAIT, M_QUAL, M_RUN, M_DEAD} mphase_t;
    mphase_t ph = M_PULSE;
    int      age = 0;
    int      tries = 0;
    int      losses = 0;
    logic    d1 = 1'b0, d2 = 1'b0, ls = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph = M_PULSE; age = 0; tries = 0; losses = 0; d1 = 0; d2 = 0;
        end else begin
            ls = d2;
            d2 = d1;
            d1 = pll_lock;
            case (ph)
                M_PULSE: begin
                    age++;
                    if (age == P_RST) begin ph = M_WAIT; age = 0; end
                end
                M_WAIT: begin
                    if (ls) begin
                        ph = M_QUAL; age = 0;
                    end else begin
                        age++;
                        if (age == P_TO) begin
                            tries++;
                            age = 0;
                            ph = (tries == P_MR) ? M_DEAD : M_PULSE;
                        end
                    end
                end
                M_QUAL: begin
                    if (!ls) begin
                        ph = M_WAIT; age = 0;
                    end else begin
                        age++;
                        if (age == P_ST) begin ph = M_RUN; tries = 0; age = 0; end
                    end
                end
                M_RUN: begin
                    if (!ls) begin
                        losses = (losses < 255) ? losses + 1 : 255;
                        ph = M_PULSE; age = 0;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        check("pll_reset",   32'(pll_reset),   32'(ph == M_PULSE || ph == M_DEAD));
        check("sys_reset_n", 32'(sys_reset_n), 32'(ph == M_RUN));
        check("locked",      32'(locked),      32'(ph == M_RUN));
        check("fail",        32'(fail),        32'(ph == M_DEAD));
        check("retry_count", 32'(retry_count), 32'(tries));
        check("loss_count",  32'(loss_count),  32'(losses));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        tick(3);
        check("rst_pll_reset",   32'(pll_reset),   32'd1);
        check("rst_sys_reset_n", 32'(sys_reset_n), 32'd0);
        check("rst_locked",      32'(locked),      32'd0);
        check("rst_fail",        32'(fail),        32'd0);
        check("rst_retry",       32'(retry_count), 32'd0);
        check("rst_loss",        32'(loss_count),  32'd0);
        reset_n = 1'b1;
    endtask

    // Raise lock now and count edges until sys_reset_n rises.
    task automatic lock_to_run(input string name, input int exp_edges);
        int k;
        pll_lock = 1'b1;
        k = 0;
        while (k < 100) begin
            tick(1);
            k++;
            if (sys_reset_n) break;
        end
        check(name, 32'(k), 32'(exp_edges));
    endtask

    task automatic wait_run();
        int k;
        k = 0;
        while (!locked && k < 300) begin
            tick(1);
            k++;
        end
        check("wait_run", 32'(locked), 32'd1);
    endtask

    task automatic lose_lock_1cycle();
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
    endtask

    initial begin
        int k;

        // Clean bring-up
        do_reset();
        k = 0;
        while (k < 50) begin
            tick(1);
            k++;
            if (!pll_reset) break;
        end
        check("pulse_len", 32'(k), 32'd4);
        tick(6);
        lock_to_run("bringup_edges", 11);
        check("bringup_locked", 32'(locked), 32'd1);
        check("bringup_retry", 32'(retry_count), 32'd0);

        // Loss of lock in RUN
        lose_lock_1cycle();
        check("loss_e1", 32'(sys_reset_n), 32'd1);
        tick(1);
        check("loss_e2", 32'(sys_reset_n), 32'd1);
        tick(1);
        check("loss_e3_sysrst", 32'(sys_reset_n), 32'd0);
        check("loss_e3_locked", 32'(locked), 32'd0);
        check("loss_e3_pllrst", 32'(pll_reset), 32'd1);
        check("loss_e3_count", 32'(loss_count), 32'd1);
        wait_run();
        for (int i = 0; i < 299; i++) begin
            lose_lock_1cycle();
            tick(2);
            wait_run();
        end
        check("loss_saturate", 32'(loss_count), 32'd255);

        // Lock glitch during qualification
        do_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        tick(1);
        lock_to_run("glitch_edges", 11);
        check("glitch_retry", 32'(retry_count), 32'd0);

        // Timeout and retry then success
        do_reset();
        tick(4);
        check("to_e4_pllrst", 32'(pll_reset), 32'd0);
        tick(19);
        check("to_e23_pllrst", 32'(pll_reset), 32'd0);
        check("to_e23_retry", 32'(retry_count), 32'd0);
        tick(1);
        check("to_e24_pllrst", 32'(pll_reset), 32'd1);
        check("to_e24_retry", 32'(retry_count), 32'd1);
        tick(3);
        check("to_e27_pllrst", 32'(pll_reset), 32'd1);
        tick(1);
        check("to_e28_pllrst", 32'(pll_reset), 32'd0);
        tick(20);
        check("to_e48_pllrst", 32'(pll_reset), 32'd1);
        check("to_e48_retry", 32'(retry_count), 32'd2);
        tick(4);
        check("to_e52_pllrst", 32'(pll_reset), 32'd0);
        lock_to_run("retry_run_edges", 11);
        check("retry_cleared", 32'(retry_count), 32'd0);

        // Exhaustion
        do_reset();
        tick(71);
        check("ex_e71_fail", 32'(fail), 32'd0);
        check("ex_e71_retry", 32'(retry_count), 32'd2);
        tick(1);
        check("ex_e72_fail", 32'(fail), 32'd1);
        check("ex_e72_pllrst", 32'(pll_reset), 32'd1);
        check("ex_e72_retry", 32'(retry_count), 32'd3);
        pll_lock = 1'b1;
        tick(30);
        check("ex_sticky_fail", 32'(fail), 32'd1);
        check("ex_sticky_locked", 32'(locked), 32'd0);
        check("ex_sticky_pllrst", 32'(pll_reset), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("ex_async_fail", 32'(fail), 32'd0);
        check("ex_async_retry", 32'(retry_count), 32'd0);

        // Async reset mid-STABLE, then mid-RUN
        do_reset();
        tick(4);
        pll_lock = 1'b1;
        tick(5);
        #3 reset_n = 1'b0;
        #1;
        check("as_stb_pllrst", 32'(pll_reset), 32'd1);
        check("as_stb_sysrst", 32'(sys_reset_n), 32'd0);
        check("as_stb_locked", 32'(locked), 32'd0);
        check("as_stb_fail", 32'(fail), 32'd0);
        tick(1);
        reset_n = 1'b1;
        wait_run();
        #3 reset_n = 1'b0;
        #1;
        check("as_run_sysrst", 32'(sys_reset_n), 32'd0);
        check("as_run_locked", 32'(locked), 32'd0);
        check("as_run_pllrst", 32'(pll_reset), 32'd1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, miscompares %0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
